// File: rtl/instruction_decode_pkg.sv
// LEGv8 decode constants: opcodes, ALUSrc/ALUOp encodings and the ID/EX control bundle.
package instruction_decode_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int ZERO_REG_DEF = 31;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_SEXT = 2'b01;
  localparam logic [1:0] ALUSRC_IMM12 = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       b;
    logic       bz;
    logic       bnz;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alusrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file, 2 async read ports with XZR and same-cycle writeback bypass.
// Reads are combinational; the write lands on the rising edge.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rd_addr1,
  input  logic [4:0]      rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [0:31];
  logic            wr_ok;

  assign wr_ok = wr_en && (wr_addr != 5'(ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Bypass lets the instruction in ID see a value retiring this very cycle.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    rd_data2 = mem[rd_addr2];
    if (wr_ok && wr_addr == rd_addr1) rd_data1 = wr_data;
    if (wr_ok && wr_addr == rd_addr2) rd_data2 = wr_data;
    if (rd_addr1 == 5'(ZERO_REG)) rd_data1 = '0;
    if (rd_addr2 == 5'(ZERO_REG)) rd_data2 = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 ID stage + ID/EX register: 1-cycle latency; load-use stall and branch flush
// both load a bubble (flush > stall > illegal > normal).
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            illegal,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_address,
  output logic [31:0]     ex_instruction,
  output logic [XLEN-1:0] ex_sign_ext,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [1:0]      ex_alusrc,
  output logic [1:0]      ex_aluop,
  output logic            ex_b,
  output logic            ex_bz,
  output logic            ex_bnz,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write
);

  ctrl_t           ctrl, ex_ctrl;
  logic            legal, uses_rn, uses_reg2, reads_regs;
  logic [4:0]      rn, reg2;
  logic [XLEN-1:0] imm, rdata1, rdata2;
  logic [10:0]     op11;
  logic            load_real, hazard;

  assign rn   = if_instr[9:5];
  assign op11 = if_instr[31:21];

  always_comb begin
    ctrl       = '0;
    legal      = 1'b0;
    uses_rn    = 1'b0;
    uses_reg2  = 1'b0;
    reads_regs = 1'b1;
    imm        = '0;
    reg2       = if_instr[20:16];
    if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
      legal = 1'b1; uses_rn = 1'b1; uses_reg2 = 1'b1;
      ctrl.alusrc = ALUSRC_REG; ctrl.aluop = ALUOP_RTYPE; ctrl.reg_write = 1'b1;
    end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
      legal = 1'b1; uses_rn = 1'b1;
      imm = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
      ctrl.alusrc = ALUSRC_SEXT; ctrl.aluop = ALUOP_ADD;
      if (op11 == OP_LDUR) begin
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
      end else begin
        reg2 = if_instr[4:0]; uses_reg2 = 1'b1; ctrl.mem_write = 1'b1;
      end
    end else if (if_instr[31:22] == OP_ADDI || if_instr[31:22] == OP_SUBI) begin
      legal = 1'b1; uses_rn = 1'b1;
      imm = {{(XLEN-12){1'b0}}, if_instr[21:10]};
      ctrl.alusrc = ALUSRC_IMM12; ctrl.aluop = ALUOP_RTYPE; ctrl.reg_write = 1'b1;
    end else if (if_instr[31:24] == OP_CBZ || if_instr[31:24] == OP_CBNZ) begin
      legal = 1'b1; uses_reg2 = 1'b1; reg2 = if_instr[4:0];
      imm = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
      ctrl.alusrc = ALUSRC_REG; ctrl.aluop = ALUOP_PASSB;
      ctrl.bz  = (if_instr[31:24] == OP_CBZ);
      ctrl.bnz = (if_instr[31:24] == OP_CBNZ);
    end else if (if_instr[31:26] == OP_B) begin
      legal = 1'b1; reads_regs = 1'b0;
      imm = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
      ctrl.b = 1'b1;
    end
  end

  register_file #(.XLEN(XLEN), .ZERO_REG(ZERO_REG)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rn),
    .rd_addr2 (reg2),
    .rd_data1 (rdata1),
    .rd_data2 (rdata2),
    .wr_en    (wb_reg_write),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  // Only sources the ID instruction really consumes can create a load-use hazard.
  assign hazard = if_valid && ex_valid && ex_ctrl.mem_read &&
                  (ex_instruction[4:0] != 5'(ZERO_REG)) &&
                  ((uses_rn && rn == ex_instruction[4:0]) ||
                   (uses_reg2 && reg2 == ex_instruction[4:0]));
  assign stall     = hazard && !flush;
  assign load_real = if_valid && legal && !flush && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_ctrl        <= '0;
      ex_address     <= '0;
      ex_instruction <= '0;
      ex_sign_ext    <= '0;
      ex_data1       <= '0;
      ex_data2       <= '0;
      illegal        <= 1'b0;
    end else begin
      illegal <= if_valid && !legal && !flush;
      if (load_real) begin
        ex_valid       <= 1'b1;
        ex_ctrl        <= ctrl;
        ex_address     <= if_pc;
        ex_instruction <= if_instr;
        ex_sign_ext    <= imm;
        ex_data1       <= reads_regs ? rdata1 : '0;
        ex_data2       <= reads_regs ? rdata2 : '0;
      end else begin
        ex_valid       <= 1'b0;
        ex_ctrl        <= '0;
        ex_address     <= '0;
        ex_instruction <= '0;
        ex_sign_ext    <= '0;
        ex_data1       <= '0;
        ex_data2       <= '0;
      end
    end
  end

  assign ex_b          = ex_ctrl.b;
  assign ex_bz         = ex_ctrl.bz;
  assign ex_bnz        = ex_ctrl.bnz;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alusrc     = ex_ctrl.alusrc;
  assign ex_aluop      = ex_ctrl.aluop;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-encoded LEGv8 words, hand-computed results.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        stall, illegal, ex_valid;
  logic [63:0] ex_address, ex_sign_ext, ex_data1, ex_data2;
  logic [31:0] ex_instruction;
  logic [1:0]  ex_alusrc, ex_aluop;
  logic        ex_b, ex_bz, ex_bnz, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_reg_write;

  int total = 0;
  int bad   = 0;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .stall(stall), .illegal(illegal), .ex_valid(ex_valid), .ex_address(ex_address),
    .ex_instruction(ex_instruction), .ex_sign_ext(ex_sign_ext), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_b(ex_b),
    .ex_bz(ex_bz), .ex_bnz(ex_bnz), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {b,bz,bnz,mem_write,mem_read,mem_to_reg,reg_write,alusrc[1:0],aluop[1:0]}
  function automatic logic [63:0] ctl();
    return 64'({ex_b, ex_bz, ex_bnz, ex_mem_write, ex_mem_read, ex_mem_to_reg,
                ex_reg_write, ex_alusrc, ex_aluop});
  endfunction

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd, rn, rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [4:0] rd, rn, input logic [11:0] im);
    return {op, im, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt, rn, input logic [8:0] ofs);
    return {op, ofs, 2'b00, rn, rt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [63:0] d);
    wb_reg_write = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic issue(input logic v, input logic [63:0] pc, input logic [31:0] ins);
    if_valid = v; if_pc = pc; if_instr = ins;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    issue(1'b0, 64'd0, 32'd0);
    wb(1'b0, 5'd0, 64'd0);
    step(); step();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_ctl", ctl(), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;

    wb(1'b1, 5'd1, 64'd5);      step();
    check("post_rst_bubble", 64'(ex_valid), 64'd0);
    wb(1'b1, 5'd2, 64'd7);      step();
    wb(1'b1, 5'd7, 64'h1234);   step();
    wb(1'b0, 5'd0, 64'd0);

    // ADD X3,X1,X2
    issue(1'b1, 64'h100, enc_r(11'b10001011000, 5'd3, 5'd1, 5'd2)); step();
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_d1", ex_data1, 64'd5);
    check("add_d2", ex_data2, 64'd7);
    check("add_ctl", ctl(), 64'b0000001_00_10);
    check("add_pc", ex_address, 64'h100);

    // ADDI X8,X4,#3 while X4=0x99 is written back in the same cycle
    issue(1'b1, 64'h104, enc_i(10'b1001000100, 5'd8, 5'd4, 12'd3));
    wb(1'b1, 5'd4, 64'h99); step();
    check("bypass_d1", ex_data1, 64'h99);
    check("addi_imm", ex_sign_ext, 64'd3);
    check("addi_ctl", ctl(), 64'b0000001_10_10);

    // ADD X9,X31,X31 while X31 is being written: XZR wins over bypass
    issue(1'b1, 64'h108, enc_r(11'b10001011000, 5'd9, 5'd31, 5'd31));
    wb(1'b1, 5'd31, 64'h55); step();
    check("xzr_bypass_d1", ex_data1, 64'd0);
    wb(1'b0, 5'd0, 64'd0); step();
    check("xzr_store_d2", ex_data2, 64'd0);

    // LDUR X5,[X1,#-8] then ADD X6,X5,X2 -> one stall, one bubble
    issue(1'b1, 64'h10C, enc_d(11'b11111000010, 5'd5, 5'd1, 9'h1F8)); step();
    check("ldur_imm", ex_sign_ext, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_ctl", ctl(), 64'b0000111_01_00);
    check("ldur_d1", ex_data1, 64'd5);
    issue(1'b1, 64'h110, enc_r(11'b10001011000, 5'd6, 5'd5, 5'd2)); #1;
    check("lu_stall", 64'(stall), 64'd1);
    step();
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_bubble_ctl", ctl(), 64'd0);
    check("lu_stall_drop", 64'(stall), 64'd0);
    step();
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_pc", ex_address, 64'h110);
    check("lu_add_d2", ex_data2, 64'd7);

    // CBZ X7,#-1
    issue(1'b1, 64'h114, {8'b10110100, 19'h7FFFF, 5'd7}); step();
    check("cbz_imm", ex_sign_ext, 64'hFFFF_FFFF_FFFF_FFFF);
    check("cbz_d2", ex_data2, 64'h1234);
    check("cbz_ctl", ctl(), 64'b0100000_00_01);

    // STUR X2,[X1,#16]
    issue(1'b1, 64'h118, enc_d(11'b11111000000, 5'd2, 5'd1, 9'd16)); step();
    check("stur_d2", ex_data2, 64'd7);
    check("stur_ctl", ctl(), 64'b0001000_01_00);
    check("stur_imm", ex_sign_ext, 64'd16);

    // B #3
    issue(1'b1, 64'h11C, {6'b000101, 26'd3}); step();
    check("b_imm", ex_sign_ext, 64'd3);
    check("b_ctl", ctl(), 64'b1000000_00_00);

    // Flush arriving during a load-use hazard
    issue(1'b1, 64'h120, enc_d(11'b11111000010, 5'd5, 5'd1, 9'd0)); step();
    issue(1'b1, 64'h124, enc_r(11'b10001011000, 5'd6, 5'd5, 5'd2));
    flush = 1'b1; #1;
    check("flush_stall", 64'(stall), 64'd0);
    step();
    flush = 1'b0;
    check("flush_bubble", 64'(ex_valid), 64'd0);
    check("flush_ctl", ctl(), 64'd0);

    // Undecodable word
    issue(1'b1, 64'h128, 32'hFFFF_FFFF); step();
    check("ill_pulse", 64'(illegal), 64'd1);
    check("ill_valid", 64'(ex_valid), 64'd0);
    issue(1'b0, 64'd0, 32'd0); step();
    check("ill_clear", 64'(illegal), 64'd0);

    // Async reset mid-stream, then register file must be cleared
    issue(1'b1, 64'h200, enc_r(11'b10001011000, 5'd3, 5'd1, 5'd2)); step();
    check("pre_arst_valid", 64'(ex_valid), 64'd1);
    #2 rst_n = 1'b0; #1;
    check("arst_valid", 64'(ex_valid), 64'd0);
    check("arst_d1", ex_data1, 64'd0);
    check("arst_ctl", ctl(), 64'd0);
    step();
    rst_n = 1'b1; step();
    check("rf_cleared_d1", ex_data1, 64'd0);
    check("rf_cleared_valid", 64'(ex_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
